// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the 5-stage core: datapath width, reset PC,
// the canonical NOP encoding, the IF/ID payload struct and a saturating
// increment used by the fetch performance counters.
package pipe_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } if_id_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register bank. Flush inserts a bubble and takes priority
// over stall; stall holds the current contents; otherwise the fetch-side
// payload is captured.
module if_id_reg
  import pipe_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = pipe_pkg::NOP_INSTR
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   stall,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  localparam if_id_t BUBBLE = '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0};

  // Register bank: reset/flush -> bubble, stall -> hold, else capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= BUBBLE;
    end else if (flush) begin
      q <= BUBBLE;
    end else if (!stall) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC register and next-PC mux, drives the
// instruction-memory address, and feeds the IF/ID register bank.
// Optional feature macro: FETCH_PERF_CNT_EN builds saturating stall/flush
// counters; without it StallCount/FlushCount are tied to zero.
module fetch_stage
  import pipe_pkg::*;
#(
  parameter int              XLEN      = pipe_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = pipe_pkg::RESET_PC,
  parameter logic [31:0]     NOP_INSTR = pipe_pkg::NOP_INSTR
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            STALLF,
  input  logic            STALLD,
  input  logic            FLUSHD,
  input  logic            PCSRCE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic [31:0]     InstrF,
  output logic [XLEN-1:0] PCF,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD,
  output logic [31:0]     StallCount,
  output logic [31:0]     FlushCount
);

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] target_aligned;
  if_id_t          if_id_d;
  if_id_t          if_id_q;

  // Redirect targets are word-aligned by dropping the low two bits; no trap.
  assign target_aligned = PCTargetE & ~XLEN'(3);
  assign pc_plus4       = PCF + XLEN'(4);

  // Next-PC select: a redirect always wins over a fetch stall.
  always_comb begin
    pc_next = pc_plus4;
    if (PCSRCE) begin
      pc_next = target_aligned;
    end else if (STALLF) begin
      pc_next = PCF;
    end
  end

  // PC register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      PCF <= RESET_PC;
    end else begin
      PCF <= pc_next;
    end
  end

  assign if_id_d = '{instr: InstrF, pc: PCF, pc_plus4: pc_plus4, valid: 1'b1};

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk  (CLK),
    .rst_n(RST),
    .stall(STALLD),
    .flush(FLUSHD),
    .d    (if_id_d),
    .q    (if_id_q)
  );

  assign InstrD   = if_id_q.instr;
  assign PCD      = if_id_q.pc;
  assign PCPlus4D = if_id_q.pc_plus4;
  assign ValidD   = if_id_q.valid;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  // Performance counters: a stall overridden by a redirect is not counted.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (STALLF && !PCSRCE) stall_cnt <= sat_inc(stall_cnt);
      if (FLUSHD)            flush_cnt <= sat_inc(flush_cnt);
    end
  end

  assign StallCount = stall_cnt;
  assign FlushCount = flush_cnt;
`else
  assign StallCount = '0;
  assign FlushCount = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage. Instruction memory is modelled
// as a PC-tagged word so every captured instruction identifies its address.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stallf;
  logic        stalld;
  logic        flushd;
  logic        pcsrce;
  logic [31:0] target;
  logic [31:0] instr_f;
  logic [31:0] pcf;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
  logic [31:0] stall_count;
  logic [31:0] flush_count;

  int tests;
  int fails;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_stage dut (
    .CLK       (clk),
    .RST       (rst),
    .STALLF    (stallf),
    .STALLD    (stalld),
    .FLUSHD    (flushd),
    .PCSRCE    (pcsrce),
    .PCTargetE (target),
    .InstrF    (instr_f),
    .PCF       (pcf),
    .InstrD    (instr_d),
    .PCD       (pc_d),
    .PCPlus4D  (pc_plus4_d),
    .ValidD    (valid_d),
    .StallCount(stall_count),
    .FlushCount(flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] tag(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  // Combinational instruction memory.
  always_comb instr_f = tag(pcf);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        sf, sd, fd, ps;
    logic [31:0] tgt;
    logic [31:0] e_pcf, e_instr, e_pcd, e_p4d;
    logic        e_valid;
  } vec_t;

  vec_t vecs[16];

  task automatic check_state(input string tagname, input logic [31:0] e_pcf,
                             input logic [31:0] e_instr, input logic [31:0] e_pcd,
                             input logic [31:0] e_p4d, input logic e_valid);
    check({tagname, ".PCF"},      pcf,        e_pcf);
    check({tagname, ".InstrD"},   instr_d,    e_instr);
    check({tagname, ".PCD"},      pc_d,       e_pcd);
    check({tagname, ".PCPlus4D"}, pc_plus4_d, e_p4d);
    check({tagname, ".ValidD"},   {31'd0, valid_d}, {31'd0, e_valid});
  endtask

  task automatic drive(input logic sf, input logic sd, input logic fd,
                       input logic ps, input logic [31:0] tgt);
    stallf = sf; stalld = sd; flushd = fd; pcsrce = ps; target = tgt;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    drive(0, 0, 0, 0, 32'h0);
    rst = 1'b0;

    //          sf sd fd ps target        pcf           instrD               pcD           pc+4D         v
    vecs[0]  = '{0, 0, 0, 0, 32'h0,        32'h4,        tag(32'h0),          32'h0,        32'h4,        1};
    vecs[1]  = '{0, 0, 0, 0, 32'h0,        32'h8,        tag(32'h4),          32'h4,        32'h8,        1};
    vecs[2]  = '{1, 1, 0, 0, 32'h0,        32'h8,        tag(32'h4),          32'h4,        32'h8,        1};
    vecs[3]  = '{1, 1, 0, 0, 32'h0,        32'h8,        tag(32'h4),          32'h4,        32'h8,        1};
    vecs[4]  = '{1, 1, 0, 0, 32'h0,        32'h8,        tag(32'h4),          32'h4,        32'h8,        1};
    vecs[5]  = '{0, 0, 0, 0, 32'h0,        32'hC,        tag(32'h8),          32'h8,        32'hC,        1};
    vecs[6]  = '{0, 0, 1, 1, 32'h103,      32'h100,      NOP,                 32'h0,        32'h0,        0};
    vecs[7]  = '{0, 0, 0, 0, 32'h0,        32'h104,      tag(32'h100),        32'h100,      32'h104,      1};
    vecs[8]  = '{1, 1, 1, 1, 32'h40,       32'h40,       NOP,                 32'h0,        32'h0,        0};
    vecs[9]  = '{0, 0, 0, 0, 32'h0,        32'h44,       tag(32'h40),         32'h40,       32'h44,       1};
    vecs[10] = '{0, 1, 0, 0, 32'h0,        32'h48,       tag(32'h40),         32'h40,       32'h44,       1};
    vecs[11] = '{0, 0, 0, 0, 32'h0,        32'h4C,       tag(32'h48),         32'h48,       32'h4C,       1};
    vecs[12] = '{0, 0, 0, 1, 32'hFFFFFFFE, 32'hFFFFFFFC, tag(32'h4C),         32'h4C,       32'h50,       1};
    vecs[13] = '{0, 0, 0, 0, 32'h0,        32'h0,        tag(32'hFFFFFFFC),   32'hFFFFFFFC, 32'h0,        1};
    vecs[14] = '{1, 0, 0, 0, 32'h0,        32'h0,        tag(32'h0),          32'h0,        32'h4,        1};
    vecs[15] = '{1, 0, 0, 0, 32'h0,        32'h0,        tag(32'h0),          32'h0,        32'h4,        1};

    // Reset state, sampled while RST is held low.
    #12;
    check_state("reset", 32'h0, NOP, 32'h0, 32'h0, 1'b0);
    check("reset.StallCount", stall_count, 32'h0);
    check("reset.FlushCount", flush_count, 32'h0);
    rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].sf, vecs[i].sd, vecs[i].fd, vecs[i].ps, vecs[i].tgt);
      @(posedge clk);
      #1;
      check_state($sformatf("vec%0d", i), vecs[i].e_pcf, vecs[i].e_instr,
                  vecs[i].e_pcd, vecs[i].e_p4d, vecs[i].e_valid);
    end

    // Five counted stalls (vecs 2-4, 14, 15; vec 8's stall lost to redirect), two flushes.
`ifdef FETCH_PERF_CNT_EN
    check("cnt.StallCount", stall_count, 32'd5);
    check("cnt.FlushCount", flush_count, 32'd2);
`else
    check("cnt.StallCount", stall_count, 32'd0);
    check("cnt.FlushCount", flush_count, 32'd0);
`endif

    // Redirect to 0x20, then stall and pulse reset between clock edges.
    drive(0, 0, 0, 1, 32'h20);
    @(posedge clk);
    #1;
    check("pre_rst.PCF", pcf, 32'h20);
    drive(1, 1, 0, 0, 32'h0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_state("async_rst", 32'h0, NOP, 32'h0, 32'h0, 1'b0);
    check("async_rst.StallCount", stall_count, 32'h0);
    check("async_rst.FlushCount", flush_count, 32'h0);
    @(negedge clk);
    drive(0, 0, 0, 0, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_state("post_rst", 32'h4, tag(32'h0), 32'h0, 32'h4, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard stop so the bench can never hang.
  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
